// File: rtl/switch_output_allocator_pkg.sv
// rtl/switch_output_allocator_pkg.sv - shared types and helpers for the output-port switch allocator
package switch_output_allocator_pkg;

    localparam int MAX_SRC_WIDTH = 8;

    typedef enum logic [0:0] {
        ALLOC_IDLE  = 1'b0,
        ALLOC_GRANT = 1'b1
    } alloc_state_t;

    // Per-output grant record; the switch top concatenates these into its grant vector.
    typedef struct packed {
        logic                     valid;
        logic [MAX_SRC_WIDTH-1:0] src_port;
    } alloc_grant_t;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_output_allocator_rr_arbiter.sv
// rtl/switch_output_allocator_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module switch_output_allocator_rr_arbiter
    import switch_output_allocator_pkg::*;
#(
    parameter int N = 5,
    parameter int W = index_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx
);

    // Scan positions ptr, ptr+1, ... with wrap; the first set request wins.
    always_comb begin
        int           pos;
        logic [W-1:0] pos_idx;
        logic         found;
        onehot  = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = pos[W-1:0];
            if (!found && req[pos_idx]) begin
                found           = 1'b1;
                onehot[pos_idx] = 1'b1;
                idx             = pos_idx;
            end
        end
    end

endmodule

// File: rtl/switch_output_allocator.sv
// rtl/switch_output_allocator.sv - per-output switch allocator with round-robin and whole-message credits
module switch_output_allocator
    import switch_output_allocator_pkg::*;
#(
    parameter int   NUM_PORTS                     = 5,
    parameter int   PORT_NUM                      = 0,
    parameter int   FLITS_PER_MESSAGE             = 4,
    parameter int   MAX_FLITS_PER_PORT_DOWNSTREAM = 16,
    parameter int   MAX_CREDIT_WIDTH              = 5,
    parameter bit   DISABLE_UTURN                 = 1'b0,
    localparam int  PORT_WIDTH                    = index_width(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_in,
    output logic                        grant_valid_out,
    output logic [PORT_WIDTH-1:0]       grant_src_out,
    input  logic                        flit_sent_in,
    input  logic                        credit_valid_in,
    input  logic [MAX_CREDIT_WIDTH-1:0] credit_count_in,
    output logic                        credack_out,
    output logic [MAX_CREDIT_WIDTH-1:0] credits_out,
    output logic                        overflow_err_out
);

    localparam int              CW          = MAX_CREDIT_WIDTH + 1;
    localparam int              FW          = index_width(FLITS_PER_MESSAGE);
    localparam logic [CW-1:0]   MSG_CREDITS = CW'(FLITS_PER_MESSAGE);
    localparam logic [CW-1:0]   MAX_CREDITS = CW'(MAX_FLITS_PER_PORT_DOWNSTREAM);
    localparam logic [FW-1:0]   LAST_FLIT   = FW'(FLITS_PER_MESSAGE - 1);
    localparam logic [PORT_WIDTH-1:0] LAST_PORT = PORT_WIDTH'(NUM_PORTS - 1);

    alloc_state_t                state;
    logic [MAX_CREDIT_WIDTH-1:0] credits;
    logic [PORT_WIDTH-1:0]       rr_ptr;
    logic [FW-1:0]               flit_cnt;

    logic [NUM_PORTS-1:0]        masked_req;
    logic [NUM_PORTS-1:0]        win_onehot;
    logic [PORT_WIDTH-1:0]       win_idx;
    logic [PORT_WIDTH-1:0]       ptr_next;
    logic                        take;
    logic [CW-1:0]               credits_ext;
    logic [CW-1:0]               credit_sum;
    logic                        credit_over;
    logic [CW-1:0]               credit_next;

    switch_output_allocator_rr_arbiter #(
        .N (NUM_PORTS),
        .W (PORT_WIDTH)
    ) u_rr_arbiter (
        .req    (masked_req),
        .ptr    (rr_ptr),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    // Eligibility uses the credit count from before this cycle's return is added.
    always_comb begin
        masked_req = req_in;
        if (DISABLE_UTURN) begin
            masked_req[PORT_NUM] = 1'b0;
        end
        credits_ext = {1'b0, credits};
        take        = (state == ALLOC_IDLE) && (|win_onehot) && (credits_ext >= MSG_CREDITS);
        credit_sum  = credits_ext
                    - (take ? MSG_CREDITS : '0)
                    + (credit_valid_in ? {1'b0, credit_count_in} : '0);
        credit_over = credit_sum > MAX_CREDITS;
        credit_next = credit_over ? MAX_CREDITS : credit_sum;
        ptr_next    = (win_idx == LAST_PORT) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ALLOC_IDLE;
            grant_valid_out  <= 1'b0;
            grant_src_out    <= '0;
            credits          <= MAX_CREDIT_WIDTH'(MAX_FLITS_PER_PORT_DOWNSTREAM);
            rr_ptr           <= '0;
            flit_cnt         <= '0;
            credack_out      <= 1'b0;
            overflow_err_out <= 1'b0;
        end else begin
            credits     <= credit_next[MAX_CREDIT_WIDTH-1:0];
            credack_out <= credit_valid_in;
            if (credit_over) begin
                overflow_err_out <= 1'b1;
            end
            case (state)
                ALLOC_IDLE: begin
                    if (take) begin
                        state           <= ALLOC_GRANT;
                        grant_valid_out <= 1'b1;
                        grant_src_out   <= win_idx;
                        rr_ptr          <= ptr_next;
                        flit_cnt        <= '0;
                    end
                end
                ALLOC_GRANT: begin
                    if (flit_sent_in) begin
                        if (flit_cnt == LAST_FLIT) begin
                            state           <= ALLOC_IDLE;
                            grant_valid_out <= 1'b0;
                            flit_cnt        <= '0;
                        end else begin
                            flit_cnt <= flit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= ALLOC_IDLE;
                    grant_valid_out <= 1'b0;
                end
            endcase
        end
    end

    assign credits_out = credits;

endmodule

// File: tb/tb_switch_output_allocator.sv
// tb/tb_switch_output_allocator.sv - directed vector bench for switch_output_allocator
module tb_switch_output_allocator;

    logic       clk;
    logic       rst;
    logic [4:0] req_in;
    logic       flit_sent_in;
    logic       credit_valid_in;
    logic [4:0] credit_count_in;
    logic       grant_valid_out;
    logic [2:0] grant_src_out;
    logic       credack_out;
    logic [4:0] credits_out;
    logic       overflow_err_out;

    logic       rst1;
    logic [4:0] req1;
    logic       flit1;
    logic       cv1;
    logic [4:0] cc1;
    logic       gv1;
    logic [2:0] src1;
    logic       ack1;
    logic [4:0] cr1;
    logic       ovf1;

    int errors;
    int checks;

    switch_output_allocator dut (
        .clk              (clk),
        .rst              (rst),
        .req_in           (req_in),
        .grant_valid_out  (grant_valid_out),
        .grant_src_out    (grant_src_out),
        .flit_sent_in     (flit_sent_in),
        .credit_valid_in  (credit_valid_in),
        .credit_count_in  (credit_count_in),
        .credack_out      (credack_out),
        .credits_out      (credits_out),
        .overflow_err_out (overflow_err_out)
    );

    switch_output_allocator #(
        .PORT_NUM      (3),
        .DISABLE_UTURN (1'b1)
    ) dut_uturn (
        .clk              (clk),
        .rst              (rst1),
        .req_in           (req1),
        .grant_valid_out  (gv1),
        .grant_src_out    (src1),
        .flit_sent_in     (flit1),
        .credit_valid_in  (cv1),
        .credit_count_in  (cc1),
        .credack_out      (ack1),
        .credits_out      (cr1),
        .overflow_err_out (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic       fs;
        logic       cv;
        logic [4:0] cc;
        logic       chk_src;
        logic       gv;
        logic [2:0] src;
        logic [4:0] cr;
        logic       ack;
        logic       ovf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [4:0] q, logic f, logic v, logic [4:0] c,
                                logic cs, logic g, logic [2:0] s, logic [4:0] cr,
                                logic a, logic o);
        vec_t t;
        t.rst = r; t.req = q; t.fs = f; t.cv = v; t.cc = c;
        t.chk_src = cs; t.gv = g; t.src = s; t.cr = cr; t.ack = a; t.ovf = o;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Underflow would wrap the counter far above the downstream depth.
    always @(negedge clk) begin
        if (!rst && credits_out > 5'd16) begin
            errors++;
            $display("FAIL credit_range: got %0d expected <= 16", credits_out);
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; req_in = '0; flit_sent_in = 1'b0; credit_valid_in = 1'b0; credit_count_in = '0;
        rst1 = 1'b1; req1 = '0; flit1 = 1'b0; cv1 = 1'b0; cc1 = '0;

        //              rst req      fs cv cc  chk gv src cr  ack ovf
        vq.push_back(mk(1, 5'b00000, 0, 0, 0,  1, 0, 0, 16, 0, 0));
        vq.push_back(mk(0, 5'b00100, 0, 0, 0,  1, 1, 2, 12, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 5'b00000, 1, 0, 0, 1, 1, 2, 12, 0, 0));
        vq.push_back(mk(0, 5'b00000, 1, 0, 0,  0, 0, 0, 12, 0, 0));
        vq.push_back(mk(1, 5'b00000, 0, 0, 0,  1, 0, 0, 16, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 0, 0,  1, 1, 0, 12, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 5'b10011, 1, 0, 0, 1, 1, 0, 12, 0, 0));
        vq.push_back(mk(0, 5'b10011, 1, 0, 0,  0, 0, 0, 12, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 0, 0,  1, 1, 1, 8, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 5'b10011, 1, 0, 0, 1, 1, 1, 8, 0, 0));
        vq.push_back(mk(0, 5'b10011, 1, 0, 0,  0, 0, 0, 8, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 0, 0,  1, 1, 4, 4, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 5'b10011, 1, 0, 0, 1, 1, 4, 4, 0, 0));
        vq.push_back(mk(0, 5'b10011, 1, 0, 0,  0, 0, 0, 4, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 0, 0,  1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 5'b10011, 1, 0, 0, 1, 1, 0, 0, 0, 0));
        vq.push_back(mk(0, 5'b10011, 1, 0, 0,  0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 0, 0,  0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 1, 4,  0, 0, 0, 4, 1, 0));
        vq.push_back(mk(0, 5'b10011, 0, 0, 0,  1, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 5'b10011, 1, 1, 4,  1, 1, 1, 4, 1, 0));
        vq.push_back(mk(0, 5'b10011, 1, 1, 4,  1, 1, 1, 8, 1, 0));
        vq.push_back(mk(0, 5'b10011, 1, 0, 0,  1, 1, 1, 8, 0, 0));
        vq.push_back(mk(0, 5'b10011, 1, 0, 0,  0, 0, 0, 8, 0, 0));
        vq.push_back(mk(0, 5'b10011, 0, 1, 3,  1, 1, 4, 7, 1, 0));
        vq.push_back(mk(0, 5'b00000, 1, 1, 9,  1, 1, 4, 16, 1, 0));
        vq.push_back(mk(0, 5'b00000, 1, 1, 1,  1, 1, 4, 16, 1, 1));
        vq.push_back(mk(0, 5'b00000, 1, 0, 0,  1, 1, 4, 16, 0, 1));
        vq.push_back(mk(0, 5'b00000, 1, 0, 0,  0, 0, 0, 16, 0, 1));
        vq.push_back(mk(0, 5'b00000, 0, 0, 0,  0, 0, 0, 16, 0, 1));
        vq.push_back(mk(0, 5'b00001, 0, 0, 0,  1, 1, 0, 12, 0, 1));
        vq.push_back(mk(0, 5'b00001, 1, 0, 0,  1, 1, 0, 12, 0, 1));
        vq.push_back(mk(0, 5'b00001, 1, 0, 0,  1, 1, 0, 12, 0, 1));
        vq.push_back(mk(1, 5'b00001, 1, 0, 0,  1, 0, 0, 16, 0, 0));
        vq.push_back(mk(0, 5'b00000, 1, 0, 0,  0, 0, 0, 16, 0, 0));
        vq.push_back(mk(0, 5'b00010, 0, 0, 0,  1, 1, 1, 12, 0, 0));

        foreach (vq[i]) begin
            @(negedge clk);
            rst             = vq[i].rst;
            req_in          = vq[i].req;
            flit_sent_in    = vq[i].fs;
            credit_valid_in = vq[i].cv;
            credit_count_in = vq[i].cc;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_grant_valid", i), int'(grant_valid_out), int'(vq[i].gv));
            check($sformatf("v%0d_credits", i), int'(credits_out), int'(vq[i].cr));
            check($sformatf("v%0d_credack", i), int'(credack_out), int'(vq[i].ack));
            check($sformatf("v%0d_overflow", i), int'(overflow_err_out), int'(vq[i].ovf));
            if (vq[i].chk_src) begin
                check($sformatf("v%0d_grant_src", i), int'(grant_src_out), int'(vq[i].src));
            end
        end

        @(negedge clk);
        rst1 = 1'b0;
        req1 = 5'b01000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("uturn_masked_gv_%0d", i), int'(gv1), 0);
            check($sformatf("uturn_masked_cr_%0d", i), int'(cr1), 16);
        end
        @(negedge clk);
        req1 = 5'b01001;
        @(posedge clk);
        #1;
        check("uturn_other_gv", int'(gv1), 1);
        check("uturn_other_src", int'(src1), 0);
        check("uturn_other_cr", int'(cr1), 12);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
